// File: rtl/ddr_ring_buffer_ctrl_pkg.sv
// Purpose : shared definitions for the DDR ring buffer run-control sequencer
//           (FSM state encoding, error codes, config validity check).
// Users   : ddr_ring_buffer_ctrl, host register map, verification bench.
package ddr_ring_buffer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_BAD_CFG   = 2'b01;
  localparam logic [1:0] ERR_DATA_LOSS = 2'b10;
  localparam logic [1:0] ERR_DRAIN_TMO = 2'b11;

  // A ring config is usable when it has at least one slot, its base is
  // burst aligned, and the base lies entirely inside the address mask.
  function automatic logic cfg_is_valid(input logic [31:0] len,
                                        input logic [31:0] base,
                                        input logic [31:0] mask,
                                        input logic [31:0] align_mask);
    return (len != 32'd0) &&
           ((base & align_mask) == 32'd0) &&
           ((base & ~mask) == 32'd0);
  endfunction

endpackage

// File: rtl/ddr_ring_buffer_ctrl.sv
// Purpose : run-control sequencer for the DDR ring buffer: latch/check config,
//           timed soft reset, run with EOB acknowledge/IRQ, drain on STOP.
// Latency : every output is registered, 1 cycle from the causing input.
// Flow    : no backpressure; EOB is a level handshake (RB_DDR_EOB held by the
//           ring buffer until RB_CLEAR_EOB pulses).
// Ports   : CLK/RSTN; START/STOP pulses and CFG_* from the host; RB_* pins to
//           the ring buffer; BUSY/DONE/ERROR/ERR_CODE/EOB_COUNT/IRQ status.
module ddr_ring_buffer_ctrl
  import ddr_ring_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DRAIN_BURST_LEN = 128,
  parameter int unsigned SOFT_RST_CYCLES = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 65535
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic        STOP,
  input  logic [31:0] CFG_RING_BUFFER_LEN,
  input  logic [31:0] CFG_BASE_ADDR,
  input  logic [31:0] CFG_ADDR_MASK,
  output logic [31:0] RB_RING_BUFFER_LEN,
  output logic [31:0] RB_AXI_BASE_ADDR,
  output logic [31:0] RB_AXI_ADDR_MASK,
  output logic        RB_SOFT_RSTN,
  input  logic        RB_DDR_EOB,
  output logic        RB_CLEAR_EOB,
  input  logic        RB_EMPTY,
  input  logic        RB_DATA_LOSS,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE,
  output logic [31:0] EOB_COUNT,
  output logic        IRQ
);

  localparam int unsigned BURST_BYTES = DRAIN_BURST_LEN * DATA_WIDTH / 8;
  localparam logic [31:0] ALIGN_MASK  = 32'(BURST_BYTES - 1);
  localparam logic [31:0] RST_LAST    = 32'(SOFT_RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = 32'(DRAIN_TIMEOUT - 1);

  state_e      state_q,     state_d;
  logic [31:0] timer_q,     timer_d;
  logic [31:0] eob_cnt_q,   eob_cnt_d;
  logic        clear_eob_q, clear_eob_d;
  logic        irq_q,       irq_d;
  logic        done_q,      done_d;
  logic [1:0]  err_code_q,  err_code_d;
  logic [31:0] ring_len_q,  ring_len_d;
  logic [31:0] base_q,      base_d;
  logic [31:0] mask_q,      mask_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    eob_cnt_d   = eob_cnt_q;
    clear_eob_d = 1'b0;
    irq_d       = 1'b0;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    ring_len_d  = ring_len_q;
    base_d      = base_q;
    mask_d      = mask_q;

    case (state_q)
      ST_IDLE: begin
        // STOP beats a coincident START; the START is simply dropped.
        if (!STOP && START) begin
          ring_len_d = CFG_RING_BUFFER_LEN;
          base_d     = CFG_BASE_ADDR;
          mask_d     = CFG_ADDR_MASK;
          eob_cnt_d  = 32'd0;
          err_code_d = ERR_NONE;
          if (cfg_is_valid(CFG_RING_BUFFER_LEN, CFG_BASE_ADDR, CFG_ADDR_MASK, ALIGN_MASK)) begin
            state_d = ST_RESET;
            timer_d = 32'd0;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_BAD_CFG;
          end
        end
      end

      ST_RESET: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (timer_q == RST_LAST) begin
          state_d = ST_RUN;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_RUN: begin
        if (RB_DATA_LOSS) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DATA_LOSS;
        end else if (STOP) begin
          state_d = ST_DRAIN;
          timer_d = 32'd0;
        end
      end

      ST_DRAIN: begin
        if (RB_DATA_LOSS) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DATA_LOSS;
        end else if (RB_EMPTY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DRAIN_TMO;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_ERR: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // EOB acknowledge. While clear_eob_q is high the ring buffer has not yet
    // seen the clear, so the still-high flag must not be counted again. An EOB
    // coinciding with leaving the active states is left unacknowledged.
    if ((state_q == ST_RUN || state_q == ST_DRAIN) &&
        (state_d == ST_RUN || state_d == ST_DRAIN) &&
        RB_DDR_EOB && !clear_eob_q) begin
      clear_eob_d = 1'b1;
      irq_d       = 1'b1;
      if (eob_cnt_q != 32'hFFFF_FFFF) begin
        eob_cnt_d = eob_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      timer_q     <= 32'd0;
      eob_cnt_q   <= 32'd0;
      clear_eob_q <= 1'b0;
      irq_q       <= 1'b0;
      done_q      <= 1'b0;
      err_code_q  <= ERR_NONE;
      ring_len_q  <= 32'd0;
      base_q      <= 32'd0;
      mask_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      eob_cnt_q   <= eob_cnt_d;
      clear_eob_q <= clear_eob_d;
      irq_q       <= irq_d;
      done_q      <= done_d;
      err_code_q  <= err_code_d;
      ring_len_q  <= ring_len_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
    end
  end

  // Status decodes come straight off the state register, so they carry the
  // same one-cycle latency as the other registered outputs.
  assign RB_SOFT_RSTN       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign BUSY               = (state_q == ST_RESET) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ERROR              = (state_q == ST_ERR);
  assign DONE               = done_q;
  assign ERR_CODE           = err_code_q;
  assign EOB_COUNT          = eob_cnt_q;
  assign IRQ                = irq_q;
  assign RB_CLEAR_EOB       = clear_eob_q;
  assign RB_RING_BUFFER_LEN = ring_len_q;
  assign RB_AXI_BASE_ADDR   = base_q;
  assign RB_AXI_ADDR_MASK   = mask_q;

endmodule

// File: tb/tb_ddr_ring_buffer_ctrl.sv
// Purpose : self-checking bench for ddr_ring_buffer_ctrl (run, EOB ack,
//           drain, bad config, data loss, drain timeout, async reset).
// Timing  : inputs driven and outputs sampled 1 time unit after posedge CLK.
module tb_ddr_ring_buffer_ctrl;
  import ddr_ring_buffer_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN, START, STOP;
  logic [31:0] CFG_RING_BUFFER_LEN, CFG_BASE_ADDR, CFG_ADDR_MASK;
  logic [31:0] RB_RING_BUFFER_LEN, RB_AXI_BASE_ADDR, RB_AXI_ADDR_MASK;
  logic        RB_SOFT_RSTN, RB_DDR_EOB, RB_CLEAR_EOB, RB_EMPTY, RB_DATA_LOSS;
  logic        BUSY, DONE, ERROR, IRQ;
  logic [1:0]  ERR_CODE;
  logic [31:0] EOB_COUNT;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_cnt;
  int          irq_mon = 0;

  always #5 CLK = ~CLK;

  ddr_ring_buffer_ctrl #(
    .DATA_WIDTH(32), .DRAIN_BURST_LEN(128), .SOFT_RST_CYCLES(16), .DRAIN_TIMEOUT(100)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .STOP(STOP),
    .CFG_RING_BUFFER_LEN(CFG_RING_BUFFER_LEN), .CFG_BASE_ADDR(CFG_BASE_ADDR),
    .CFG_ADDR_MASK(CFG_ADDR_MASK),
    .RB_RING_BUFFER_LEN(RB_RING_BUFFER_LEN), .RB_AXI_BASE_ADDR(RB_AXI_BASE_ADDR),
    .RB_AXI_ADDR_MASK(RB_AXI_ADDR_MASK), .RB_SOFT_RSTN(RB_SOFT_RSTN),
    .RB_DDR_EOB(RB_DDR_EOB), .RB_CLEAR_EOB(RB_CLEAR_EOB), .RB_EMPTY(RB_EMPTY),
    .RB_DATA_LOSS(RB_DATA_LOSS), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_CODE(ERR_CODE), .EOB_COUNT(EOB_COUNT), .IRQ(IRQ)
  );

  // Independent IRQ pulse counter.
  always @(posedge CLK) begin
    #1;
    if (IRQ === 1'b1) irq_mon++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] len, input logic [31:0] base, input logic [31:0] mask);
    CFG_RING_BUFFER_LEN = len;
    CFG_BASE_ADDR       = base;
    CFG_ADDR_MASK       = mask;
    START = 1'b1;
    tick();
    START = 1'b0;
    model_cnt = 32'd0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (RB_SOFT_RSTN !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // One EOB handshake: flag held through the clear cycle, then dropped.
  task automatic do_eob();
    int n;
    logic [31:0] e;
    RB_DDR_EOB = 1'b1;
    model_cnt  = model_cnt + 32'd1;
    exp_q.push_back(model_cnt);
    n = 0;
    while (RB_CLEAR_EOB !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (RB_CLEAR_EOB !== 1'b1) begin
      errors++;
      $display("FAIL eob_clear_timeout: RB_CLEAR_EOB=%b after %0d cycles, required 1", RB_CLEAR_EOB, n);
    end else begin
      checks++;
      if (IRQ !== 1'b1) begin
        errors++;
        $display("FAIL eob_irq: IRQ=%b with RB_CLEAR_EOB, required 1", IRQ);
      end
      e = exp_q.pop_front();
      checks++;
      if (EOB_COUNT !== e) begin
        errors++;
        $display("FAIL eob_count: EOB_COUNT=%0d, required %0d", EOB_COUNT, e);
      end
    end
    tick();
    checks++;
    if (RB_CLEAR_EOB !== 1'b0 || IRQ !== 1'b0 || EOB_COUNT !== model_cnt) begin
      errors++;
      $display("FAIL eob_no_double: clr=%b irq=%b cnt=%0d, required 0 0 %0d",
               RB_CLEAR_EOB, IRQ, EOB_COUNT, model_cnt);
    end
    RB_DDR_EOB = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({RB_SOFT_RSTN, BUSY, DONE, ERROR, IRQ, RB_CLEAR_EOB, ERR_CODE} !== 8'b0) begin
      errors++;
      $display("FAIL %s_flags: srstn=%b busy=%b done=%b err=%b irq=%b clr=%b code=%b, required all 0",
               tag, RB_SOFT_RSTN, BUSY, DONE, ERROR, IRQ, RB_CLEAR_EOB, ERR_CODE);
    end
    checks++;
    if ({RB_RING_BUFFER_LEN, RB_AXI_BASE_ADDR, RB_AXI_ADDR_MASK, EOB_COUNT} !== 128'b0) begin
      errors++;
      $display("FAIL %s_regs: len=%h base=%h mask=%h cnt=%h, required 0",
               tag, RB_RING_BUFFER_LEN, RB_AXI_BASE_ADDR, RB_AXI_ADDR_MASK, EOB_COUNT);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b1; START = 1'b0; STOP = 1'b0; RB_DDR_EOB = 1'b0; RB_EMPTY = 1'b0;
    RB_DATA_LOSS = 1'b0; CFG_RING_BUFFER_LEN = '0; CFG_BASE_ADDR = '0; CFG_ADDR_MASK = '0;
    model_cnt = '0;
    #2 RSTN = 1'b0;
    #10;
    check_reset_values("reset");
    tick();
    RSTN = 1'b1;
    tick();
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_clean_run();
    int n;
    pulse_start(32'd4, 32'h1000_0000, 32'hF000_0000);
    checks++;
    if (BUSY !== 1'b1 || RB_SOFT_RSTN !== 1'b0 || EOB_COUNT !== 32'd0 || ERROR !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_state: busy=%b srstn=%b cnt=%0d err=%b, required 1 0 0 0",
               BUSY, RB_SOFT_RSTN, EOB_COUNT, ERROR);
    end
    checks++;
    if (RB_RING_BUFFER_LEN !== 32'd4 || RB_AXI_BASE_ADDR !== 32'h1000_0000 ||
        RB_AXI_ADDR_MASK !== 32'hF000_0000) begin
      errors++;
      $display("FAIL run_cfg_latch: len=%h base=%h mask=%h, required 4 10000000 f0000000",
               RB_RING_BUFFER_LEN, RB_AXI_BASE_ADDR, RB_AXI_ADDR_MASK);
    end
    wait_run(n);
    checks++;
    if (n != 16 || RB_SOFT_RSTN !== 1'b1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL soft_reset_len: released after %0d cycles (srstn=%b busy=%b), required 16 1 1",
               n, RB_SOFT_RSTN, BUSY);
    end
  endtask

  task automatic test_eob_ack();
    int irq0;
    irq0 = irq_mon;
    for (int i = 0; i < 3; i++) do_eob();
    checks++;
    if (EOB_COUNT !== 32'd3 || (irq_mon - irq0) != 3) begin
      errors++;
      $display("FAIL eob_total: EOB_COUNT=%0d irq_pulses=%0d, required 3 3", EOB_COUNT, irq_mon - irq0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL eob_scoreboard: %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stop_drain();
    logic early_done;
    pulse_stop();
    checks++;
    if (BUSY !== 1'b1 || RB_SOFT_RSTN !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: busy=%b srstn=%b done=%b, required 1 1 0", BUSY, RB_SOFT_RSTN, DONE);
    end
    early_done = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (DONE === 1'b1 || BUSY !== 1'b1) early_done = 1'b1;
    end
    checks++;
    if (early_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_early: left DRAIN before RB_EMPTY (flag=%b), required 0", early_done);
    end
    RB_EMPTY = 1'b1;
    tick();
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || RB_SOFT_RSTN !== 1'b0 || ERROR !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: done=%b busy=%b srstn=%b err=%b, required 1 0 0 0",
               DONE, BUSY, RB_SOFT_RSTN, ERROR);
    end
    RB_EMPTY = 1'b0;
    tick();
    checks++;
    if (DONE !== 1'b0 || EOB_COUNT !== 32'd3 || RB_AXI_BASE_ADDR !== 32'h1000_0000) begin
      errors++;
      $display("FAIL drain_after: done=%b cnt=%0d base=%h, required 0 3 10000000",
               DONE, EOB_COUNT, RB_AXI_BASE_ADDR);
    end
  endtask

  task automatic test_start_stop_same();
    CFG_RING_BUFFER_LEN = 32'd8; CFG_BASE_ADDR = 32'h2000_0000; CFG_ADDR_MASK = 32'hF000_0000;
    START = 1'b1; STOP = 1'b1;
    tick();
    START = 1'b0; STOP = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || ERROR !== 1'b0 || RB_RING_BUFFER_LEN !== 32'd4) begin
      errors++;
      $display("FAIL start_stop_same: busy=%b err=%b len=%0d, required 0 0 4", BUSY, ERROR, RB_RING_BUFFER_LEN);
    end
  endtask

  task automatic test_bad_config();
    // base not aligned to 512-byte bursts
    pulse_start(32'd4, 32'h0000_0100, 32'hF000_0FFF);
    checks++;
    if (ERROR !== 1'b1 || ERR_CODE !== ERR_BAD_CFG || RB_SOFT_RSTN !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL bad_align: err=%b code=%b srstn=%b busy=%b, required 1 01 0 0",
               ERROR, ERR_CODE, RB_SOFT_RSTN, BUSY);
    end
    pulse_start(32'd4, 32'h1000_0000, 32'hF000_0000);
    checks++;
    if (ERROR !== 1'b1 || RB_AXI_BASE_ADDR !== 32'h0000_0100) begin
      errors++;
      $display("FAIL err_start_ignored: err=%b base=%h, required 1 00000100", ERROR, RB_AXI_BASE_ADDR);
    end
    pulse_stop();
    checks++;
    if (ERROR !== 1'b0 || ERR_CODE !== ERR_BAD_CFG || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL err_stop: err=%b code=%b busy=%b, required 0 01 0", ERROR, ERR_CODE, BUSY);
    end
    // zero-length ring
    pulse_start(32'd0, 32'h1000_0000, 32'hF000_0000);
    checks++;
    if (ERROR !== 1'b1 || ERR_CODE !== ERR_BAD_CFG || RB_SOFT_RSTN !== 1'b0) begin
      errors++;
      $display("FAIL bad_len: err=%b code=%b srstn=%b, required 1 01 0", ERROR, ERR_CODE, RB_SOFT_RSTN);
    end
    pulse_stop();
    // base outside mask
    pulse_start(32'd4, 32'h3000_0000, 32'h1000_0000);
    checks++;
    if (ERROR !== 1'b1 || ERR_CODE !== ERR_BAD_CFG) begin
      errors++;
      $display("FAIL bad_mask: err=%b code=%b, required 1 01", ERROR, ERR_CODE);
    end
    pulse_stop();
  endtask

  task automatic test_data_loss();
    int n;
    pulse_start(32'd4, 32'h1000_0000, 32'hF000_0000);
    checks++;
    if (ERR_CODE !== ERR_NONE || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL start_clears_code: code=%b busy=%b, required 00 1", ERR_CODE, BUSY);
    end
    wait_run(n);
    RB_DATA_LOSS = 1'b1;
    STOP = 1'b1;
    tick();
    RB_DATA_LOSS = 1'b0;
    STOP = 1'b0;
    checks++;
    if (ERROR !== 1'b1 || ERR_CODE !== ERR_DATA_LOSS || RB_SOFT_RSTN !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL data_loss: err=%b code=%b srstn=%b busy=%b, required 1 10 0 0",
               ERROR, ERR_CODE, RB_SOFT_RSTN, BUSY);
    end
    pulse_stop();
    checks++;
    if (ERROR !== 1'b0 || ERR_CODE !== ERR_DATA_LOSS) begin
      errors++;
      $display("FAIL data_loss_stop: err=%b code=%b, required 0 10", ERROR, ERR_CODE);
    end
  endtask

  task automatic test_drain_timeout();
    int n;
    pulse_start(32'd4, 32'h1000_0000, 32'hF000_0000);
    wait_run(n);
    pulse_stop();
    n = 0;
    while (ERROR !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 100 || ERR_CODE !== ERR_DRAIN_TMO || RB_SOFT_RSTN !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: error after %0d cycles code=%b srstn=%b, required 100 11 0",
               n, ERR_CODE, RB_SOFT_RSTN);
    end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    int n;
    pulse_start(32'd4, 32'h1000_0000, 32'hF000_0000);
    wait_run(n);
    for (int i = 0; i < 5; i++) do_eob();
    checks++;
    if (EOB_COUNT !== 32'd5) begin
      errors++;
      $display("FAIL pre_reset_count: EOB_COUNT=%0d, required 5", EOB_COUNT);
    end
    #2 RSTN = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_eob_ack();
    test_stop_drain();
    test_start_stop_same();
    test_bad_config();
    test_data_loss();
    test_drain_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
